// File: rtl/top.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : top
// Brief    : DDR3 DIMM power-up/initialisation sequencer with periodic
//            refresh. Macro TOP_FAST_INIT_EN selects short timing.
// Revision : 1.0
// ============================================================================
module top #(
    parameter int T_RST_CYC  = 40000,
    parameter int T_CKE_CYC  = 100000,
    parameter int T_REFI_CYC = 1560
) (
    input  logic        sysclk_p,
    input  logic        sysclk_n,
    input  logic        sysrst,
    output logic [7:0]  gpio_led,
    inout  wire  [63:0] ddr_dq,
    inout  wire  [7:0]  ddr_dqs_p,
    inout  wire  [7:0]  ddr_dqs_n,
    output logic [15:0] ddr_addr,
    output logic [2:0]  ddr_ba,
    output logic        ddr_ras_n,
    output logic        ddr_cas_n,
    output logic        ddr_we_n,
    output logic        ddr_reset_n,
    output logic [1:0]  ddr_ck_p,
    output logic [1:0]  ddr_ck_n,
    output logic [1:0]  ddr_cke,
    output logic [1:0]  ddr_cs_n,
    output logic [1:0]  ddr_odt,
    output logic [7:0]  ddr_dm
);

`ifdef TOP_FAST_INIT_EN
    localparam int c_rst_cyc  = 200;
    localparam int c_cke_cyc  = 500;
    localparam int c_zq_cyc   = 64;
    localparam int c_refi_cyc = 200;
`else
    localparam int c_rst_cyc  = T_RST_CYC;
    localparam int c_cke_cyc  = T_CKE_CYC;
    localparam int c_zq_cyc   = 512;
    localparam int c_refi_cyc = T_REFI_CYC;
`endif

    localparam logic [16:0] c_rst_last  = 17'(c_rst_cyc - 1);
    localparam logic [16:0] c_cke_last  = 17'(c_cke_cyc - 1);
    localparam logic [16:0] c_refi_last = 17'(c_refi_cyc - 1);
    localparam logic [16:0] c_txpr_last = 17'd63;
    localparam logic [16:0] c_tmrd      = 17'd4;
    localparam logic [16:0] c_tmod      = 17'd12;
    localparam logic [16:0] c_tzq       = 17'(c_zq_cyc);
    localparam logic [16:0] c_trp       = 17'd4;
    localparam logic [16:0] c_trfc      = 17'd32;

    localparam logic [2:0] c_cmd_mrs  = 3'b000;
    localparam logic [2:0] c_cmd_ref  = 3'b001;
    localparam logic [2:0] c_cmd_pre  = 3'b010;
    localparam logic [2:0] c_cmd_zqcl = 3'b110;
    localparam logic [2:0] c_cmd_nop  = 3'b111;

    typedef enum logic [3:0] {
        RST_WAIT = 4'd0,
        CKE_WAIT = 4'd1,
        MRS2     = 4'd2,
        MRS3     = 4'd3,
        MRS1     = 4'd4,
        MRS0     = 4'd5,
        ZQCL     = 4'd6,
        IDLE     = 4'd7,
        PREA     = 4'd8,
        REF      = 4'd9
    } state_t;

    // Differential receiver; a vendor input-buffer primitive replaces this on silicon.
    logic w_clk;
    assign w_clk = sysclk_p & ~sysclk_n;

    state_t      r_state, w_state;
    logic [16:0] r_cnt, w_cnt;
    logic [16:0] r_refi, w_refi;
    logic        r_init_done, w_init_done;
    logic        r_ref_tog, w_ref_tog;
    logic        r_reset_n, w_reset_n;
    logic [1:0]  r_cke, w_cke;
    logic [1:0]  r_cs_n, w_cs_n;
    logic [2:0]  r_cmd, w_cmd;
    logic [15:0] r_addr, w_addr;
    logic [2:0]  r_ba, w_ba;

    // Each command state issues its command on the entry edge, then counts
    // its NOP gap; reaching the gap length issues the next command.
    always_comb begin
        w_state     = r_state;
        w_cnt       = r_cnt + 17'd1;
        w_refi      = r_refi + 17'd1;
        w_init_done = r_init_done;
        w_ref_tog   = r_ref_tog;
        w_reset_n   = r_reset_n;
        w_cke       = r_cke;
        w_cmd       = c_cmd_nop;
        w_addr      = 16'h0000;
        w_ba        = 3'd0;

        case (r_state)
            RST_WAIT: begin
                if (r_cnt == c_rst_last) begin
                    w_reset_n = 1'b1;
                    w_cnt     = 17'd0;
                    w_state   = CKE_WAIT;
                end
            end
            CKE_WAIT: begin
                if (!r_cke[0]) begin
                    if (r_cnt == c_cke_last) begin
                        w_cke = 2'b11;
                        w_cnt = 17'd0;
                    end
                end else if (r_cnt == c_txpr_last) begin
                    w_state = MRS2;
                    w_cmd   = c_cmd_mrs;
                    w_ba    = 3'd2;
                    w_addr  = 16'h0008;
                    w_cnt   = 17'd0;
                end
            end
            MRS2: begin
                if (r_cnt == c_tmrd) begin
                    w_state = MRS3;
                    w_cmd   = c_cmd_mrs;
                    w_ba    = 3'd3;
                    w_addr  = 16'h0000;
                    w_cnt   = 17'd0;
                end
            end
            MRS3: begin
                if (r_cnt == c_tmrd) begin
                    w_state = MRS1;
                    w_cmd   = c_cmd_mrs;
                    w_ba    = 3'd1;
                    w_addr  = 16'h0004;
                    w_cnt   = 17'd0;
                end
            end
            MRS1: begin
                if (r_cnt == c_tmrd) begin
                    // BL8, CL6, WR6, DLL reset
                    w_state = MRS0;
                    w_cmd   = c_cmd_mrs;
                    w_ba    = 3'd0;
                    w_addr  = 16'h0520;
                    w_cnt   = 17'd0;
                end
            end
            MRS0: begin
                if (r_cnt == c_tmod) begin
                    w_state = ZQCL;
                    w_cmd   = c_cmd_zqcl;
                    w_addr  = 16'h0400;
                    w_cnt   = 17'd0;
                end
            end
            ZQCL: begin
                if (r_cnt == c_tzq) begin
                    w_state     = IDLE;
                    w_init_done = 1'b1;
                    w_refi      = 17'd0;
                end
            end
            IDLE: begin
                if (r_refi == c_refi_last) begin
                    w_state = PREA;
                    w_cmd   = c_cmd_pre;
                    w_addr  = 16'h0400;
                    w_refi  = 17'd0;
                    w_cnt   = 17'd0;
                end
            end
            PREA: begin
                if (r_cnt == c_trp) begin
                    w_state   = REF;
                    w_cmd     = c_cmd_ref;
                    w_ref_tog = ~r_ref_tog;
                    w_cnt     = 17'd0;
                end
            end
            REF: begin
                if (r_cnt == c_trfc) begin
                    w_state = IDLE;
                end
            end
            default: begin
                w_state = RST_WAIT;
                w_cnt   = 17'd0;
            end
        endcase

        w_cs_n = w_cke[0] ? 2'b00 : 2'b11;
    end

    always_ff @(posedge w_clk or negedge sysrst) begin
        if (!sysrst) begin
            r_state     <= RST_WAIT;
            r_cnt       <= 17'd0;
            r_refi      <= 17'd0;
            r_init_done <= 1'b0;
            r_ref_tog   <= 1'b0;
            r_reset_n   <= 1'b0;
            r_cke       <= 2'b00;
            r_cs_n      <= 2'b11;
            r_cmd       <= c_cmd_nop;
            r_addr      <= 16'h0000;
            r_ba        <= 3'd0;
        end else begin
            r_state     <= w_state;
            r_cnt       <= w_cnt;
            r_refi      <= w_refi;
            r_init_done <= w_init_done;
            r_ref_tog   <= w_ref_tog;
            r_reset_n   <= w_reset_n;
            r_cke       <= w_cke;
            r_cs_n      <= w_cs_n;
            r_cmd       <= w_cmd;
            r_addr      <= w_addr;
            r_ba        <= w_ba;
        end
    end

    assign ddr_ck_p    = {2{w_clk}};
    assign ddr_ck_n    = {2{~w_clk}};
    assign ddr_dq      = 'z;
    assign ddr_dqs_p   = 'z;
    assign ddr_dqs_n   = 'z;
    assign ddr_dm      = 8'h00;
    assign ddr_odt     = 2'b00;
    assign ddr_reset_n = r_reset_n;
    assign ddr_cke     = r_cke;
    assign ddr_cs_n    = r_cs_n;
    assign ddr_ras_n   = r_cmd[2];
    assign ddr_cas_n   = r_cmd[1];
    assign ddr_we_n    = r_cmd[0];
    assign ddr_addr    = r_addr;
    assign ddr_ba      = r_ba;
    assign gpio_led    = {r_state, 2'b00, r_ref_tog, r_init_done};

endmodule
`default_nettype wire

// File: tb/tb_top.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_top
// Brief    : Scoreboard bench for the DDR3 init/refresh sequencer.
// Revision : 1.0
// ============================================================================
module tb_top;

`ifdef TOP_FAST_INIT_EN
    localparam int RST = 200, CKE = 500, ZQ = 64, REFI = 200;
`else
    localparam int RST = 30, CKE = 70, ZQ = 512, REFI = 150;
`endif

    typedef struct {
        int          kind;   // 0 reset_n rise, 1 cke rise, 2 command, 3 init_done rise
        int          cyc;
        logic [2:0]  cmd;
        logic [2:0]  ba;
        logic [15:0] addr;
        logic [7:0]  led;
    } evt_t;

    evt_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;

    logic        sysclk_p = 1'b0;
    wire         sysclk_n;
    logic        sysrst   = 1'b0;
    wire  [7:0]  gpio_led;
    wire  [63:0] ddr_dq;
    wire  [7:0]  ddr_dqs_p, ddr_dqs_n;
    wire  [15:0] ddr_addr;
    wire  [2:0]  ddr_ba;
    wire         ddr_ras_n, ddr_cas_n, ddr_we_n, ddr_reset_n;
    wire  [1:0]  ddr_ck_p, ddr_ck_n, ddr_cke, ddr_cs_n, ddr_odt;
    wire  [7:0]  ddr_dm;

    assign sysclk_n = ~sysclk_p;
    always #2.5 sysclk_p = ~sysclk_p;

    top #(.T_RST_CYC(30), .T_CKE_CYC(70), .T_REFI_CYC(150)) dut (
        .sysclk_p(sysclk_p), .sysclk_n(sysclk_n), .sysrst(sysrst),
        .gpio_led(gpio_led), .ddr_dq(ddr_dq), .ddr_dqs_p(ddr_dqs_p),
        .ddr_dqs_n(ddr_dqs_n), .ddr_addr(ddr_addr), .ddr_ba(ddr_ba),
        .ddr_ras_n(ddr_ras_n), .ddr_cas_n(ddr_cas_n), .ddr_we_n(ddr_we_n),
        .ddr_reset_n(ddr_reset_n), .ddr_ck_p(ddr_ck_p), .ddr_ck_n(ddr_ck_n),
        .ddr_cke(ddr_cke), .ddr_cs_n(ddr_cs_n), .ddr_odt(ddr_odt), .ddr_dm(ddr_dm)
    );

    // Clock count since reset release: the first rising edge after release is 1.
    always @(posedge sysclk_p) cyc <= sysrst ? cyc + 1 : 0;

    task automatic push(input int kind, input int c, input logic [2:0] cmd,
                        input logic [2:0] ba, input logic [15:0] addr, input logic [7:0] led);
        evt_t e;
        e.kind = kind; e.cyc = c; e.cmd = cmd; e.ba = ba; e.addr = addr; e.led = led;
        exp_q.push_back(e);
    endtask

    task automatic push_init(input int nref);
        int   t;
        logic tog;
        t = RST;     push(0, t, 3'b111, 3'd0, 16'h0000, 8'h10);
        t += CKE;    push(1, t, 3'b111, 3'd0, 16'h0000, 8'h10);
        t += 64;     push(2, t, 3'b000, 3'd2, 16'h0008, 8'h20);
        t += 5;      push(2, t, 3'b000, 3'd3, 16'h0000, 8'h30);
        t += 5;      push(2, t, 3'b000, 3'd1, 16'h0004, 8'h40);
        t += 5;      push(2, t, 3'b000, 3'd0, 16'h0520, 8'h50);
        t += 13;     push(2, t, 3'b110, 3'd0, 16'h0400, 8'h60);
        t += ZQ + 1; push(3, t, 3'b111, 3'd0, 16'h0000, 8'h71);
        tog = 1'b0;
        for (int i = 0; i < nref; i++) begin
            t += REFI;
            push(2, t, 3'b010, 3'd0, 16'h0400, {4'h8, 2'b00, tog, 1'b1});
            tog = ~tog;
            push(2, t + 5, 3'b001, 3'd0, 16'h0000, {4'h9, 2'b00, tog, 1'b1});
        end
    endtask

    task automatic wait_empty(input int bound);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < bound) begin
            @(negedge sysclk_p);
            n++;
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL timeout: %0d events pending, next kind=%0d expected at cyc=%0d",
                     exp_q.size(), exp_q[0].kind, exp_q[0].cyc);
            exp_q.delete();
        end
    endtask

    task automatic check_reset_state(input string name);
        logic [36:0] got;
        got = {ddr_reset_n, ddr_cke, ddr_cs_n, ddr_ras_n, ddr_cas_n, ddr_we_n,
               ddr_addr, ddr_ba, gpio_led};
        checks++;
        if (got !== {1'b0, 2'b00, 2'b11, 3'b111, 16'h0000, 3'd0, 8'h00}) begin
            errors++;
            $display("FAIL %s: rstn=%b cke=%b cs_n=%b cmd=%b addr=%h ba=%0d led=%h, need 0/00/11/111/0000/0/00",
                     name, ddr_reset_n, ddr_cke, ddr_cs_n, {ddr_ras_n, ddr_cas_n, ddr_we_n},
                     ddr_addr, ddr_ba, gpio_led);
        end
    endtask

    // Monitor: detect observable events and compare against the scoreboard.
    logic prev_rstn = 1'b0, prev_cke = 1'b0, prev_done = 1'b0;
    int   mon_kind;
    bit   mon_ev;
    evt_t mon_e;
    always @(negedge sysclk_p) begin
        if (sysrst) begin
            mon_ev = 1'b0;
            mon_kind = 0;
            if (ddr_reset_n && !prev_rstn) begin
                mon_ev = 1'b1; mon_kind = 0;
            end else if (ddr_cke[0] && !prev_cke) begin
                mon_ev = 1'b1; mon_kind = 1;
            end else if (gpio_led[0] && !prev_done) begin
                mon_ev = 1'b1; mon_kind = 3;
            end else if (ddr_cs_n == 2'b00 && {ddr_ras_n, ddr_cas_n, ddr_we_n} != 3'b111) begin
                mon_ev = 1'b1; mon_kind = 2;
            end
            if (mon_ev) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected event kind=%0d at cyc=%0d cmd=%b ba=%0d addr=%h",
                             mon_kind, cyc, {ddr_ras_n, ddr_cas_n, ddr_we_n}, ddr_ba, ddr_addr);
                end else begin
                    mon_e = exp_q.pop_front();
                    if (mon_kind != mon_e.kind || cyc != mon_e.cyc ||
                        {ddr_ras_n, ddr_cas_n, ddr_we_n} != mon_e.cmd || ddr_ba != mon_e.ba ||
                        ddr_addr != mon_e.addr || gpio_led != mon_e.led) begin
                        errors++;
                        $display("FAIL event: got kind=%0d cyc=%0d cmd=%b ba=%0d addr=%h led=%h, expected kind=%0d cyc=%0d cmd=%b ba=%0d addr=%h led=%h",
                                 mon_kind, cyc, {ddr_ras_n, ddr_cas_n, ddr_we_n}, ddr_ba, ddr_addr,
                                 gpio_led, mon_e.kind, mon_e.cyc, mon_e.cmd, mon_e.ba, mon_e.addr,
                                 mon_e.led);
                    end
                end
            end
            checks++;
            if (ddr_dm != 8'h00 || ddr_odt != 2'b00 || ddr_ck_n != ~ddr_ck_p ||
                (ddr_cs_n == 2'b00 && {ddr_ras_n, ddr_cas_n, ddr_we_n} == 3'b111 &&
                 (ddr_addr != 16'h0000 || ddr_ba != 3'd0))) begin
                errors++;
                $display("FAIL static pins at cyc=%0d: dm=%h odt=%b ck_p=%b ck_n=%b cs_n=%b addr=%h ba=%0d",
                         cyc, ddr_dm, ddr_odt, ddr_ck_p, ddr_ck_n, ddr_cs_n, ddr_addr, ddr_ba);
            end
        end
        prev_rstn <= ddr_reset_n;
        prev_cke  <= ddr_cke[0];
        prev_done <= gpio_led[0];
    end

    initial begin
        repeat (5) @(negedge sysclk_p);
        check_reset_state("reset_state");

        // Full init, two refresh periods, then reset while REF's tRFC is running.
        push_init(2);
        sysrst = 1'b1;
        wait_empty(RST + CKE + ZQ + 2 * REFI + 400);
        repeat (3) @(negedge sysclk_p);
        #1 sysrst = 1'b0;
        #1 check_reset_state("reset_mid_ref");

        // Init must restart from the beginning after release.
        @(negedge sysclk_p);
        push_init(1);
        sysrst = 1'b1;
        wait_empty(RST + CKE + ZQ + REFI + 400);
        repeat (45) @(negedge sysclk_p);
        checks++;
        if (gpio_led != 8'h73) begin
            errors++;
            $display("FAIL idle_after_ref: led=%h, need 73", gpio_led);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/top.md
TOP -- requirements
Module: top

Interface
REQ-001 Parameters (name, default, meaning): T_RST_CYC, 40000, cycles ddr_reset_n held low after reset release (200 us at 5 ns).
REQ-002 T_CKE_CYC, 100000, cycles from ddr_reset_n high to ddr_cke high (500 us).
REQ-003 T_REFI_CYC, 1560, cycles between refresh starts (7.8 us).
REQ-004 Ports (name direction width meaning): sysclk_p in 1 differential clock positive; sysclk_n in 1 negative; the single clock, 200 MHz.
REQ-005 sysrst in 1 reset, asynchronous, active-low.
REQ-006 gpio_led out 8 status LEDs.
REQ-007 ddr_dq inout 64 DQ bus; ddr_dqs_p/ddr_dqs_n inout 8 each, strobes.
REQ-008 ddr_addr out 16 address; ddr_ba out 3 bank address.
REQ-009 ddr_ras_n, ddr_cas_n, ddr_we_n out 1 each, command pins.
REQ-010 ddr_reset_n out 1 DRAM reset; ddr_ck_p/ddr_ck_n out 2 each, DIMM clocks.
REQ-011 ddr_cke out 2, ddr_cs_n out 2, ddr_odt out 2 per rank; ddr_dm out 8 data mask.

Function
REQ-012 Internal clock clk = differential receive of sysclk_p/sysclk_n; all logic on rising clk.
REQ-013 ddr_ck_p = {2{clk}}, ddr_ck_n = {2{~clk}}, free-running, unaffected by reset.
REQ-014 ddr_dq, ddr_dqs_p, ddr_dqs_n always high-Z; ddr_dm = 0; ddr_odt = 0.
REQ-015 All command outputs registered; commands target both ranks (ddr_cs_n=00) for one cycle, NOP (cs_n=00, ras/cas/we=111) otherwise after CKE high.
REQ-016 Encodings {ras,cas,we}: MRS 000, REF 001, PRE 010, ZQCL 110, NOP 111.
REQ-017 FSM, states with 4-bit code: RST_WAIT 0, CKE_WAIT 1, MRS2 2, MRS3 3, MRS1 4, MRS0 5, ZQCL 6, IDLE 7, PREA 8, REF 9.
REQ-018 RST_WAIT: reset_n=0, cke=00, cs_n=11 for T_RST_CYC cycles, then reset_n=1, go CKE_WAIT.
REQ-019 CKE_WAIT: after T_CKE_CYC cycles drive cke=11, wait 64 cycles (tXPR), go MRS2.
REQ-020 MRS2: ba=2, addr=0x0008; MRS3: ba=3, addr=0x0000; MRS1: ba=1, addr=0x0004; each followed by 4 NOP cycles (tMRD).
REQ-021 MRS0: ba=0, addr=0x0520 (BL8, CL6, WR6, DLL reset), then 12 NOP cycles (tMOD), go ZQCL.
REQ-022 ZQCL: addr=0x0400, ba=0, then 512 NOP cycles, go IDLE and set init_done.
REQ-023 IDLE: refresh counter counts clk; at T_REFI_CYC go PREA, counter restarts from 0 on entering PREA.
REQ-024 PREA: addr=0x0400, then 4 NOPs (tRP); REF: one REF, then 32 NOPs (tRFC), return IDLE.
REQ-025 Addr/ba are 0 on NOP cycles; wait counters 17-bit, terminal count exact (N-cycle wait = N NOP cycles).
REQ-026 gpio_led[0]=init_done; [1] toggles on each REF issue; [3:2]=0; [7:4]=current state code.

Reset
REQ-027 sysrst low asynchronously forces: state RST_WAIT, counters 0, ddr_reset_n=0, ddr_cke=00, ddr_cs_n=11, ras/cas/we=111, addr=0, ba=0, gpio_led=0, init_done=0.
REQ-028 Reset asserted mid-operation (including mid-refresh) restarts full init after release.

Configuration
REQ-029 Macro TOP_FAST_INIT_EN: when defined, T_RST_CYC=200, T_CKE_CYC=500, ZQCL wait 64, T_REFI_CYC=200 regardless of parameter overrides; when undefined, parameter values apply; all other behaviour identical.

Verification
REQ-030 Release sysrst -> ddr_reset_n rises exactly T_RST_CYC clocks later, ddr_cke rises T_CKE_CYC clocks after that.
REQ-031 Init command order MRS ba2/0x0008, ba3/0x0000, ba1/0x0004, ba0/0x0520, ZQCL addr 0x0400, spacing 4/4/4/12/512 NOPs; gpio_led = 0x71 in IDLE.
REQ-032 In IDLE, PRE (A10=1) then REF issued every T_REFI_CYC cycles, REF 5 cycles after PRE; gpio_led[1] toggles per REF.
REQ-033 Assert sysrst during REF state -> outputs immediately at reset values without waiting for clk, init restarts.
REQ-034 Throughout: ddr_dq/dqs high-Z, ddr_dm=0, ddr_odt=0, ddr_ck_n = ~ddr_ck_p.
REQ-035 With TOP_FAST_INIT_EN defined, ddr_reset_n rises 200 and ddr_cke 500 cycles later; IDLE reached with no DIMM model timing violation.
